uart_tx_ctrl: RTL and testbench

UART transmit controller sitting directly upstream of the TX output multiplexer. It accepts a parallel byte with a valid strobe, then runs the frame sequence: start, data LSB-first, optional parity, stop. It drives the mux select, the serial data bit and the parity bit that the multiplexer consumes. Bit timing is one CLK per bit; CLK is the baud-rate clock and is supplied by an external prescaler.

---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/uart_tx_serializer.sv | 42 ++++
 rtl/uart_tx_ctrl.sv | 129 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: FSM state encoding,
// the select codes understood by the downstream TX multiplexer, and the
// default frame width.
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_STOP   = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register with bit counter for the UART transmitter.
// The word is loaded in parallel and shifted out LSB first, one bit per
// baud clock while shifting is enabled. o_done flags the last data bit.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_serData,
    output logic                  o_done
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_bitCnt;

    // Load a fresh word on capture, otherwise shift right and count data bits.
    // The counter returns to zero after the last bit instead of wrapping.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
        end else if (i_load) begin
            r_shift  <= i_data;
            r_bitCnt <= '0;
        end else if (i_shift) begin
            r_shift  <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_bitCnt <= (r_bitCnt == LAST_CNT) ? '0 : r_bitCnt + CNT_W'(1);
        end
    end

    assign o_serData = r_shift[0];
    assign o_done    = (r_bitCnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller feeding the TX output multiplexer.
// Frame: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// One baud clock per bit. Define UART_TX_CTRL_TWO_STOP_EN for two stop bits.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] PData,
    input  logic                  DataValid,
    input  logic                  ParityEnable,
    input  logic                  ParityType,
    output logic [1:0]            MuxSelection,
    output logic                  SerData,
    output logic                  ParityBit,
    output logic                  Busy
);

    state_t r_state;
    state_t w_nextState;
    logic   r_parityEn;
    logic   r_parityBit;
    logic   w_capture;
    logic   w_shift;
    logic   w_done;
    logic   w_serData;
    logic   w_stopLast;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .i_load    (w_capture),
        .i_shift   (w_shift),
        .i_data    (PData),
        .o_serData (w_serData),
        .o_done    (w_done)
    );

    // State register; reset aborts any frame in progress and parks in IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Latch the frame configuration and its parity at capture so later input
    // changes cannot disturb the frame; parity stays stable until next capture.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_parityEn  <= 1'b0;
            r_parityBit <= 1'b0;
        end else if (w_capture) begin
            r_parityEn  <= ParityEnable;
            r_parityBit <= (^PData) ^ ParityType;
        end
    end

`ifdef UART_TX_CTRL_TWO_STOP_EN
    logic r_stopCnt;

    // Count the two stop cycles; the second one releases the FSM to IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stopCnt <= 1'b0;
        end else if (r_state == STOP) begin
            r_stopCnt <= ~r_stopCnt;
        end else begin
            r_stopCnt <= 1'b0;
        end
    end

    assign w_stopLast = r_stopCnt;
`else
    assign w_stopLast = 1'b1;
`endif

    // Next-state logic plus mux select and busy decoded from the current state.
    always_comb begin
        w_nextState  = r_state;
        w_capture    = 1'b0;
        w_shift      = 1'b0;
        MuxSelection = SEL_STOP;
        Busy         = 1'b1;
        case (r_state)
            IDLE: begin
                Busy = 1'b0;
                if (DataValid) begin
                    w_capture   = 1'b1;
                    w_nextState = START;
                end
            end
            START: begin
                MuxSelection = SEL_START;
                w_nextState  = DATA;
            end
            DATA: begin
                MuxSelection = SEL_DATA;
                w_shift      = 1'b1;
                if (w_done) begin
                    w_nextState = r_parityEn ? PARITY : STOP;
                end
            end
            PARITY: begin
                MuxSelection = SEL_PARITY;
                w_nextState  = STOP;
            end
            STOP: begin
                MuxSelection = SEL_STOP;
                if (w_stopLast) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                Busy        = 1'b0;
                w_nextState = IDLE;
            end
        endcase
    end

    assign SerData   = w_serData;
    assign ParityBit = r_parityBit;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl. A frame-level model lists the expected
// per-cycle line activity of each accepted frame in a queue; every cycle
// the DUT outputs are compared with the head of that queue (or with idle).
// Directed frames additionally pin the model with hand-computed literals.
module tb_uart_tx_ctrl;

    localparam int DW = 8;
`ifdef UART_TX_CTRL_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic          clock = 1'b0;
    logic          resetN;
    logic [DW-1:0] pData;
    logic          dataValid;
    logic          parityEnable;
    logic          parityType;
    logic [1:0]    muxSelection;
    logic          serData;
    logic          parityBit;
    logic          busy;

    uart_tx_ctrl #(
        .DATA_WIDTH (DW)
    ) dut (
        .CLK          (clock),
        .RST          (resetN),
        .PData        (pData),
        .DataValid    (dataValid),
        .ParityEnable (parityEnable),
        .ParityType   (parityType),
        .MuxSelection (muxSelection),
        .SerData      (serData),
        .ParityBit    (parityBit),
        .Busy         (busy)
    );

    // Baud clock, 10 time units per bit.
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] sel;
        bit         chkSer;
        logic       ser;
    } expCycle_t;

    expCycle_t expQ[$];
    logic      modelParity;
    int        nCompared   = 0;
    int        nMismatched = 0;
    int        recSel[0:31];
    int        recSer[0:31];
    int        recBusy[0:31];
    int        recPar[0:31];
    int        recIdx = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual=%0d required=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Expected line activity of one frame, starting the cycle after capture.
    task automatic pushFrame(input logic [DW-1:0] data, input logic pe, input logic pt);
        expQ.push_back('{sel: 2'b00, chkSer: 1'b0, ser: 1'b0});
        for (int i = 0; i < DW; i++) begin
            expQ.push_back('{sel: 2'b10, chkSer: 1'b1, ser: data[i]});
        end
        if (pe) begin
            expQ.push_back('{sel: 2'b11, chkSer: 1'b0, ser: 1'b0});
        end
        for (int i = 0; i < NSTOP; i++) begin
            expQ.push_back('{sel: 2'b01, chkSer: 1'b0, ser: 1'b0});
        end
        modelParity = (^data) ^ pt;
    endtask

    // One baud cycle: compare outputs with the model, record them, then drive
    // the inputs that the next rising edge samples.
    task automatic applyStimulus(input logic dv, input logic [DW-1:0] data, input logic pe, input logic pt);
        expCycle_t cur;
        bit        wasIdle;
        @(negedge clock);
        wasIdle = (expQ.size() == 0);
        if (wasIdle) begin
            cur = '{sel: 2'b01, chkSer: 1'b0, ser: 1'b0};
        end else begin
            cur = expQ.pop_front();
        end
        checkOutput("muxSelection", int'(muxSelection), int'(cur.sel));
        checkOutput("busy", int'(busy), wasIdle ? 0 : 1);
        if (cur.chkSer) begin
            checkOutput("serData", int'(serData), int'(cur.ser));
        end
        checkOutput("parityBit", int'(parityBit), int'(modelParity));
        if (recIdx < 32) begin
            recSel[recIdx]  = int'(muxSelection);
            recSer[recIdx]  = int'(serData);
            recBusy[recIdx] = int'(busy);
            recPar[recIdx]  = int'(parityBit);
        end
        recIdx++;
        pData        = data;
        dataValid    = dv;
        parityEnable = pe;
        parityType   = pt;
        if (dv && wasIdle) begin
            pushFrame(data, pe, pt);
        end
    endtask

    // Directed frame: DataValid in cycle 0, scrambled inputs afterwards, and
    // an optional extra DataValid with other data at cycle ignoreAt.
    task automatic runFrame(input logic [DW-1:0] data, input logic pe, input logic pt,
                            input int cycles, input int ignoreAt, input logic [DW-1:0] ignoreData);
        recIdx = 0;
        applyStimulus(1'b1, data, pe, pt);
        for (int c = 1; c < cycles; c++) begin
            if (c == ignoreAt) begin
                applyStimulus(1'b1, ignoreData, ~pe, ~pt);
            end else begin
                applyStimulus(1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
            end
        end
    endtask

    initial begin
        int bitsA5[0:7];
        int bits07[0:7];
        bitsA5 = '{1, 0, 1, 0, 0, 1, 0, 1};
        bits07 = '{1, 1, 1, 0, 0, 0, 0, 0};

        resetN       = 1'b0;
        pData        = '0;
        dataValid    = 1'b0;
        parityEnable = 1'b0;
        parityType   = 1'b0;
        modelParity  = 1'b0;
        #3;
        checkOutput("reset muxSelection", int'(muxSelection), 1);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset serData", int'(serData), 0);
        checkOutput("reset parityBit", int'(parityBit), 0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // 0xA5, no parity.
        runFrame(8'hA5, 1'b0, 1'b0, 11 + NSTOP, -1, '0);
        checkOutput("a5 start sel", recSel[1], 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("a5 data sel", recSel[2 + i], 2);
            checkOutput("a5 data bit", recSer[2 + i], bitsA5[i]);
        end
        checkOutput("a5 stop sel", recSel[10], 1);
        checkOutput("a5 last stop sel", recSel[9 + NSTOP], 1);
        checkOutput("a5 last stop busy", recBusy[9 + NSTOP], 1);
        checkOutput("a5 idle busy", recBusy[10 + NSTOP], 0);

        // 0xA5 with even, then odd parity.
        runFrame(8'hA5, 1'b1, 1'b0, 12 + NSTOP, -1, '0);
        checkOutput("a5 even parity sel", recSel[10], 3);
        checkOutput("a5 even parity bit", recPar[10], 0);
        checkOutput("a5 even stop sel", recSel[11], 1);
        runFrame(8'hA5, 1'b1, 1'b1, 12 + NSTOP, -1, '0);
        checkOutput("a5 odd parity sel", recSel[10], 3);
        checkOutput("a5 odd parity bit", recPar[10], 1);

        // 0x07 even parity with an ignored 0xFF request during DATA.
        runFrame(8'h07, 1'b1, 1'b0, 12 + NSTOP, 4, 8'hFF);
        checkOutput("07 parity bit", recPar[10], 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("07 data bit", recSer[2 + i], bits07[i]);
        end

        // Back-to-back: new request in the first idle cycle after STOP.
        recIdx = 0;
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        for (int c = 1; c < 10 + NSTOP; c++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("b2b last stop busy", recBusy[9 + NSTOP], 1);
        checkOutput("b2b gap busy", recBusy[10 + NSTOP], 0);
        checkOutput("b2b start sel", recSel[11 + NSTOP], 0);
        checkOutput("b2b start busy", recBusy[11 + NSTOP], 1);
        repeat (12 + NSTOP) applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Reset in the middle of DATA aborts the frame at once.
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1);
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midreset muxSelection", int'(muxSelection), 1);
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset serData", int'(serData), 0);
        checkOutput("midreset parityBit", int'(parityBit), 0);
        expQ.delete();
        modelParity = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("post-reset idle sel", int'(muxSelection), 1);

        // Randomized traffic, including requests while busy.
        repeat (600) begin
            applyStimulus($urandom_range(0, 3) == 0, DW'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (16) applyStimulus(1'b0, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
